atm_txn_engine: RTL and testbench

- Parametrised, synthesizable ATM session and transaction controller.
- Holds an internal account table of NUM_ACCTS entries (account, PIN, balance, lock); the host loads it through a config port.
- Runs card → PIN → menu → transaction sessions with PIN retry lockout, inactivity timeout and overflow/underflow-safe arithmetic.
- Reports every outcome as a single-cycle coded response; sits between the front-panel/host interface and the cash dispenser.

---
 rtl/atm_txn_engine.sv | 343 ++++++++++++++++++++++++++++++++++
 tb/tb_atm_txn_engine.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_txn_engine.sv
// ATM session and transaction controller.
// Holds a small account table loaded by the host and runs card -> PIN -> menu -> exec sessions.
// Every outcome is reported as a registered one-cycle response.
module atm_txn_engine #(
  parameter int unsigned NUM_ACCTS = 4,
  parameter int unsigned ACCT_W    = 12,
  parameter int unsigned PIN_W     = 12,
  parameter int unsigned BAL_W     = 16,
  parameter int unsigned AMT_W     = 8,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_ACCTS)-1:0] cfg_idx,
  input  logic [ACCT_W-1:0]            cfg_acct,
  input  logic [PIN_W-1:0]             cfg_pin,
  input  logic [BAL_W-1:0]             cfg_bal,
  input  logic                         card_valid,
  input  logic [ACCT_W-1:0]            card_acct,
  input  logic                         pin_valid,
  input  logic [PIN_W-1:0]             pin,
  input  logic                         op_valid,
  input  logic [2:0]                   op,
  input  logic [AMT_W-1:0]             amount,
  input  logic [ACCT_W-1:0]            dst_acct,
  output logic                         busy,
  output logic                         resp_valid,
  output logic [3:0]                   resp_code,
  output logic [BAL_W-1:0]             balance_out,
  output logic                         dispense,
  output logic [AMT_W-1:0]             dispense_amt
);

  localparam int unsigned IdxW = $clog2(NUM_ACCTS);
  localparam int unsigned TryW = $clog2(MAX_TRIES + 1);
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] RespOk      = 4'd0;
  localparam logic [3:0] RespBadCard = 4'd1;
  localparam logic [3:0] RespBadPin  = 4'd2;
  localparam logic [3:0] RespLocked  = 4'd3;
  localparam logic [3:0] RespInsuff  = 4'd4;
  localparam logic [3:0] RespNoDest  = 4'd5;
  localparam logic [3:0] RespOvf     = 4'd6;
  localparam logic [3:0] RespTimeout = 4'd7;
  localparam logic [3:0] RespBadOp   = 4'd8;
  localparam logic [3:0] RespBadAmt  = 4'd9;
  localparam logic [3:0] RespExit    = 4'd10;

  localparam logic [2:0] OpDeposit  = 3'b000;
  localparam logic [2:0] OpWithdraw = 3'b001;
  localparam logic [2:0] OpBalance  = 3'b010;
  localparam logic [2:0] OpTransfer = 3'b011;
  localparam logic [2:0] OpExit     = 3'b100;

  typedef enum logic [2:0] {StIdle, StCard, StPinWait, StMenu, StExec} state_e;

  // Account table
  logic [ACCT_W-1:0]    acct_q  [NUM_ACCTS];
  logic [PIN_W-1:0]     pin_q   [NUM_ACCTS];
  logic [BAL_W-1:0]     bal_q   [NUM_ACCTS];
  logic [TryW-1:0]      tries_q [NUM_ACCTS];
  logic [NUM_ACCTS-1:0] valid_q, lock_q;

  // Session state
  state_e            state_q, state_d;
  logic [ACCT_W-1:0] card_q, dst_q;
  logic [IdxW-1:0]   sess_q;
  logic [TmrW-1:0]   tmr_q;
  logic [2:0]        op_q;
  logic [AMT_W-1:0]  amt_q;

  // Registered response
  logic             resp_valid_q, resp_valid_d;
  logic [3:0]       resp_code_q, resp_code_d;
  logic [BAL_W-1:0] bal_out_q, bal_out_d;
  logic             disp_q, disp_d;
  logic [AMT_W-1:0] disp_amt_q, disp_amt_d;

  // Table update controls
  logic             sess_bal_we, dst_bal_we;
  logic [BAL_W-1:0] sess_bal_wd, dst_bal_wd;
  logic             tries_clr, tries_inc, lock_set;

  // Lookup and datapath
  logic             card_hit, dst_hit;
  logic [IdxW-1:0]  card_idx, dst_idx;
  logic [BAL_W-1:0] sess_bal, dst_bal, amt_ext;
  logic [BAL_W:0]   dep_sum, xfer_sum;
  logic             pin_match, lock_now, tmo_hit, amt_zero, amt_gt_bal;

  assign busy         = (state_q != StIdle);
  assign resp_valid   = resp_valid_q;
  assign resp_code    = resp_code_q;
  assign balance_out  = bal_out_q;
  assign dispense     = disp_q;
  assign dispense_amt = disp_amt_q;

  // Account lookup; scanning downwards lets the lowest matching index win
  always_comb begin
    card_hit = 1'b0;
    card_idx = '0;
    dst_hit  = 1'b0;
    dst_idx  = '0;
    for (int i = NUM_ACCTS - 1; i >= 0; i--) begin
      if (valid_q[i] && (acct_q[i] == card_q)) begin
        card_hit = 1'b1;
        card_idx = IdxW'(i);
      end
      if (valid_q[i] && (acct_q[i] == dst_q)) begin
        dst_hit = 1'b1;
        dst_idx = IdxW'(i);
      end
    end
  end

  // Arithmetic is done one bit wider so overflow shows up as a carry
  always_comb begin
    sess_bal   = bal_q[sess_q];
    dst_bal    = bal_q[dst_idx];
    amt_ext    = BAL_W'(amt_q);
    dep_sum    = {1'b0, sess_bal} + {1'b0, amt_ext};
    xfer_sum   = {1'b0, dst_bal} + {1'b0, amt_ext};
    pin_match  = (pin == pin_q[sess_q]);
    lock_now   = (32'(tries_q[sess_q]) + 32'd1) >= MAX_TRIES;
    tmo_hit    = (tmr_q == TmrW'(TIMEOUT - 1));
    amt_zero   = (amt_q == '0);
    amt_gt_bal = (amt_ext > sess_bal);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (card_valid) state_d = StCard;
      StCard:    state_d = (!card_hit || lock_q[card_idx]) ? StIdle : StPinWait;
      StPinWait: begin
        if (pin_valid) begin
          if (pin_match)     state_d = StMenu;
          else if (lock_now) state_d = StIdle;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end
      end
      StMenu: begin
        if (op_valid)     state_d = StExec;
        else if (tmo_hit) state_d = StIdle;
      end
      StExec:    state_d = (op_q == OpExit) ? StIdle : StMenu;
      default:   state_d = StIdle;
    endcase
  end

  // Response and table-update decisions for the current state
  always_comb begin
    resp_valid_d = 1'b0;
    resp_code_d  = resp_code_q;
    bal_out_d    = bal_out_q;
    disp_d       = 1'b0;
    disp_amt_d   = disp_amt_q;
    sess_bal_we  = 1'b0;
    sess_bal_wd  = sess_bal;
    dst_bal_we   = 1'b0;
    dst_bal_wd   = dst_bal;
    tries_clr    = 1'b0;
    tries_inc    = 1'b0;
    lock_set     = 1'b0;
    unique case (state_q)
      StIdle: begin
      end
      StCard: begin
        if (!card_hit) begin
          resp_valid_d = 1'b1;
          resp_code_d  = RespBadCard;
          bal_out_d    = '0;
        end else if (lock_q[card_idx]) begin
          resp_valid_d = 1'b1;
          resp_code_d  = RespLocked;
          bal_out_d    = '0;
        end
      end
      StPinWait: begin
        if (pin_valid) begin
          resp_valid_d = 1'b1;
          if (pin_match) begin
            resp_code_d = RespOk;
            bal_out_d   = sess_bal;
            tries_clr   = 1'b1;
          end else begin
            tries_inc   = 1'b1;
            lock_set    = lock_now;
            resp_code_d = lock_now ? RespLocked : RespBadPin;
            bal_out_d   = '0;
          end
        end else if (tmo_hit) begin
          resp_valid_d = 1'b1;
          resp_code_d  = RespTimeout;
          bal_out_d    = '0;
        end
      end
      StMenu: begin
        if (!op_valid && tmo_hit) begin
          resp_valid_d = 1'b1;
          resp_code_d  = RespTimeout;
          bal_out_d    = '0;
        end
      end
      StExec: begin
        resp_valid_d = 1'b1;
        resp_code_d  = RespOk;
        bal_out_d    = sess_bal;
        case (op_q)
          OpDeposit: begin
            if (amt_zero)        resp_code_d = RespBadAmt;
            else if (dep_sum[BAL_W]) resp_code_d = RespOvf;
            else begin
              sess_bal_we = 1'b1;
              sess_bal_wd = dep_sum[BAL_W-1:0];
              bal_out_d   = dep_sum[BAL_W-1:0];
            end
          end
          OpWithdraw: begin
            if (amt_zero)        resp_code_d = RespBadAmt;
            else if (amt_gt_bal) resp_code_d = RespInsuff;
            else begin
              sess_bal_we = 1'b1;
              sess_bal_wd = sess_bal - amt_ext;
              bal_out_d   = sess_bal - amt_ext;
              disp_d      = 1'b1;
              disp_amt_d  = amt_q;
            end
          end
          OpBalance: begin
          end
          OpTransfer: begin
            if (amt_zero)                        resp_code_d = RespBadAmt;
            else if (!dst_hit || dst_idx == sess_q) resp_code_d = RespNoDest;
            else if (amt_gt_bal)                 resp_code_d = RespInsuff;
            else if (xfer_sum[BAL_W])            resp_code_d = RespOvf;
            else begin
              sess_bal_we = 1'b1;
              sess_bal_wd = sess_bal - amt_ext;
              dst_bal_we  = 1'b1;
              dst_bal_wd  = xfer_sum[BAL_W-1:0];
              bal_out_d   = sess_bal - amt_ext;
            end
          end
          OpExit: begin
            resp_code_d = RespExit;
            bal_out_d   = '0;
          end
          default: resp_code_d = RespBadOp;
        endcase
      end
      default: begin
      end
    endcase
  end

  // Response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_code_q  <= '0;
      bal_out_q    <= '0;
      disp_q       <= 1'b0;
      disp_amt_q   <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_code_q  <= resp_code_d;
      bal_out_q    <= bal_out_d;
      disp_q       <= disp_d;
      disp_amt_q   <= disp_amt_d;
    end
  end

  // Session latches: card number, matched index, and the pending operation
  always_ff @(posedge clk) begin
    if (rst) begin
      card_q <= '0;
      sess_q <= '0;
      op_q   <= '0;
      amt_q  <= '0;
      dst_q  <= '0;
    end else begin
      if (state_q == StIdle && card_valid) card_q <= card_acct;
      if (state_q == StCard) sess_q <= card_idx;
      if (state_q == StMenu && op_valid) begin
        op_q  <= op;
        amt_q <= amount;
        dst_q <= dst_acct;
      end
    end
  end

  // Idle timer: counts only while waiting for input, cleared on any accepted input or state change
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= '0;
    end else if ((state_q == StPinWait && !pin_valid) || (state_q == StMenu && !op_valid)) begin
      tmr_q <= tmr_q + TmrW'(1);
    end else begin
      tmr_q <= '0;
    end
  end

  // Account table: host writes while idle, session updates otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      lock_q  <= '0;
      for (int i = 0; i < NUM_ACCTS; i++) begin
        acct_q[i]  <= '0;
        pin_q[i]   <= '0;
        bal_q[i]   <= '0;
        tries_q[i] <= '0;
      end
    end else begin
      if (cfg_we && state_q == StIdle) begin
        acct_q[cfg_idx]  <= cfg_acct;
        pin_q[cfg_idx]   <= cfg_pin;
        bal_q[cfg_idx]   <= cfg_bal;
        valid_q[cfg_idx] <= 1'b1;
        lock_q[cfg_idx]  <= 1'b0;
        tries_q[cfg_idx] <= '0;
      end
      if (sess_bal_we) bal_q[sess_q] <= sess_bal_wd;
      if (dst_bal_we)  bal_q[dst_idx] <= dst_bal_wd;
      if (tries_clr)   tries_q[sess_q] <= '0;
      if (tries_inc)   tries_q[sess_q] <= tries_q[sess_q] + TryW'(1);
      if (lock_set)    lock_q[sess_q] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_atm_txn_engine.sv
// Randomized self-checking bench for atm_txn_engine with an array-based account model.
module tb_atm_txn_engine;

  localparam int NUM_ACCTS = 4;
  localparam int ACCT_W    = 12;
  localparam int PIN_W     = 12;
  localparam int BAL_W     = 16;
  localparam int AMT_W     = 8;
  localparam int MAX_TRIES = 3;
  localparam int TIMEOUT   = 255;
  localparam int MAX_BAL   = (1 << BAL_W) - 1;

  localparam int C_OK = 0, C_BAD_CARD = 1, C_BAD_PIN = 2, C_LOCKED = 3, C_INSUFF = 4;
  localparam int C_NO_DEST = 5, C_OVF = 6, C_TIMEOUT = 7, C_BAD_OP = 8, C_BAD_AMT = 9;
  localparam int C_EXIT = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [1:0]        cfg_idx;
  logic [ACCT_W-1:0] cfg_acct;
  logic [PIN_W-1:0]  cfg_pin;
  logic [BAL_W-1:0]  cfg_bal;
  logic              card_valid;
  logic [ACCT_W-1:0] card_acct;
  logic              pin_valid;
  logic [PIN_W-1:0]  pin;
  logic              op_valid;
  logic [2:0]        op;
  logic [AMT_W-1:0]  amount;
  logic [ACCT_W-1:0] dst_acct;
  logic              busy;
  logic              resp_valid;
  logic [3:0]        resp_code;
  logic [BAL_W-1:0]  balance_out;
  logic              dispense;
  logic [AMT_W-1:0]  dispense_amt;

  atm_txn_engine #(
    .NUM_ACCTS(NUM_ACCTS), .ACCT_W(ACCT_W), .PIN_W(PIN_W), .BAL_W(BAL_W),
    .AMT_W(AMT_W), .MAX_TRIES(MAX_TRIES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_acct(cfg_acct),
    .cfg_pin(cfg_pin), .cfg_bal(cfg_bal), .card_valid(card_valid), .card_acct(card_acct),
    .pin_valid(pin_valid), .pin(pin), .op_valid(op_valid), .op(op), .amount(amount),
    .dst_acct(dst_acct), .busy(busy), .resp_valid(resp_valid), .resp_code(resp_code),
    .balance_out(balance_out), .dispense(dispense), .dispense_amt(dispense_amt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model of the account table and session
  logic [ACCT_W-1:0] m_acct [NUM_ACCTS];
  logic [PIN_W-1:0]  m_pin  [NUM_ACCTS];
  int                m_bal  [NUM_ACCTS];
  int                m_tries[NUM_ACCTS];
  bit                m_valid[NUM_ACCTS];
  bit                m_lock [NUM_ACCTS];
  int                m_sess;
  bit                m_active;
  bit                m_menu;
  int                m_disp_amt;

  // Captured response
  bit r_got;
  int r_lat, r_code, r_bal, r_disp, r_damt;

  logic [ACCT_W-1:0] r_accts [5];
  logic [PIN_W-1:0]  r_pins  [4];

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_find(input logic [ACCT_W-1:0] a);
    for (int i = 0; i < NUM_ACCTS; i++) if (m_valid[i] && m_acct[i] == a) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_ACCTS; i++) begin
      m_valid[i] = 0; m_lock[i] = 0; m_tries[i] = 0; m_bal[i] = 0;
    end
    m_active = 0; m_menu = 0; m_disp_amt = 0; m_sess = 0;
  endtask

  // Polls resp_valid at successive falling edges, up to a budget
  task automatic wait_resp(input int budget);
    r_got = 0; r_lat = 0;
    for (int i = 0; i < budget; i++) begin
      if (resp_valid) begin
        r_got = 1; r_lat = i; r_code = resp_code; r_bal = balance_out;
        r_disp = dispense; r_damt = dispense_amt;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic expect_resp(input string tag, input int code, input int bal, input int lat);
    wait_resp(6);
    check_val({tag, "_seen"}, r_got, 1);
    if (r_got) begin
      check_val({tag, "_code"}, r_code, code);
      check_val({tag, "_bal"}, r_bal, bal);
      check_val({tag, "_lat"}, r_lat, lat);
    end
  endtask

  task automatic cfg_write(input int idx, input logic [ACCT_W-1:0] a,
                           input logic [PIN_W-1:0] p, input int b);
    @(negedge clk);
    if (!m_active) begin
      m_acct[idx] = a; m_pin[idx] = p; m_bal[idx] = b;
      m_valid[idx] = 1; m_lock[idx] = 0; m_tries[idx] = 0;
    end
    cfg_we = 1; cfg_idx = 2'(idx); cfg_acct = a; cfg_pin = p; cfg_bal = BAL_W'(b);
    @(negedge clk);
    cfg_we = 0;
  endtask

  task automatic present_card(input logic [ACCT_W-1:0] a);
    int idx;
    idx = m_find(a);
    @(negedge clk);
    card_valid = 1; card_acct = a;
    @(negedge clk);
    card_valid = 0;
    if (idx < 0) begin
      expect_resp("card", C_BAD_CARD, 0, 1);
    end else if (m_lock[idx]) begin
      expect_resp("card", C_LOCKED, 0, 1);
    end else begin
      wait_resp(3);
      check_val("card_quiet", r_got, 0);
      check_val("card_busy", busy, 1);
      m_active = 1; m_menu = 0; m_sess = idx;
    end
  endtask

  task automatic enter_pin(input logic [PIN_W-1:0] p);
    int s;
    s = m_sess;
    @(negedge clk);
    pin_valid = 1; pin = p;
    @(negedge clk);
    pin_valid = 0;
    if (p == m_pin[s]) begin
      m_tries[s] = 0; m_menu = 1;
      expect_resp("pin", C_OK, m_bal[s], 0);
    end else begin
      m_tries[s]++;
      if (m_tries[s] >= MAX_TRIES) begin
        m_lock[s] = 1; m_active = 0;
        expect_resp("pin", C_LOCKED, 0, 0);
      end else begin
        expect_resp("pin", C_BAD_PIN, 0, 0);
      end
    end
  endtask

  task automatic do_op(input int o, input int a, input logic [ACCT_W-1:0] d);
    int s, di, code, bal, disp;
    s = m_sess; di = m_find(d); disp = 0; code = C_OK;
    case (o)
      0: begin
        if (a == 0) code = C_BAD_AMT;
        else if (m_bal[s] + a > MAX_BAL) code = C_OVF;
        else m_bal[s] += a;
      end
      1: begin
        if (a == 0) code = C_BAD_AMT;
        else if (a > m_bal[s]) code = C_INSUFF;
        else begin
          m_bal[s] -= a; disp = 1; m_disp_amt = a;
        end
      end
      2: code = C_OK;
      3: begin
        if (a == 0) code = C_BAD_AMT;
        else if (di < 0 || di == s) code = C_NO_DEST;
        else if (a > m_bal[s]) code = C_INSUFF;
        else if (m_bal[di] + a > MAX_BAL) code = C_OVF;
        else begin
          m_bal[s] -= a; m_bal[di] += a;
        end
      end
      4: begin
        code = C_EXIT; m_active = 0; m_menu = 0;
      end
      default: code = C_BAD_OP;
    endcase
    bal = (o == 4) ? 0 : m_bal[s];
    @(negedge clk);
    op_valid = 1; op = 3'(o); amount = AMT_W'(a); dst_acct = d;
    @(negedge clk);
    op_valid = 0;
    expect_resp("op", code, bal, 1);
    if (r_got) begin
      check_val("op_disp", r_disp, disp);
      check_val("op_damt", r_damt, m_disp_amt);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt, a, o, n;
    bit got;
    rst = 1; cfg_we = 0; cfg_idx = '0; cfg_acct = '0; cfg_pin = '0; cfg_bal = '0;
    card_valid = 0; card_acct = '0; pin_valid = 0; pin = '0; op_valid = 0; op = '0;
    amount = '0; dst_acct = '0;
    model_reset();
    r_accts[0] = 12'h123; r_accts[1] = 12'h222; r_accts[2] = 12'h333;
    r_accts[3] = 12'h333; r_accts[4] = 12'h999;
    r_pins[0] = 12'h456; r_pins[1] = 12'h111; r_pins[2] = 12'h777; r_pins[3] = 12'h888;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_rv", resp_valid, 0);
    check_val("rst_code", resp_code, 0);
    check_val("rst_bal", balance_out, 0);
    check_val("rst_disp", dispense, 0);
    check_val("rst_damt", dispense_amt, 0);
    rst = 0;

    // Inputs other than card_valid are ignored while idle
    @(negedge clk);
    pin_valid = 1; op_valid = 1; pin = 12'h456; op = 3'd2;
    @(negedge clk);
    pin_valid = 0; op_valid = 0;
    @(negedge clk);
    check_val("idle_busy", busy, 0);
    check_val("idle_rv", resp_valid, 0);

    // Directed session flow
    cfg_write(0, 12'h123, 12'h456, 100);
    cfg_write(1, 12'h222, 12'h111, 65530);
    present_card(12'h123);
    enter_pin(12'h456);
    do_op(0, 20, 12'h000);
    do_op(1, 150, 12'h000);
    do_op(1, 50, 12'h000);
    do_op(3, 10, 12'h222);
    do_op(3, 5, 12'h222);
    do_op(2, 0, 12'h000);
    do_op(6, 1, 12'h000);
    do_op(0, 0, 12'h000);
    do_op(3, 5, 12'h123);
    do_op(3, 5, 12'h999);
    do_op(4, 0, 12'h000);
    present_card(12'h222);
    enter_pin(12'h111);
    do_op(0, 1, 12'h000);
    do_op(4, 0, 12'h000);
    present_card(12'h999);

    // PIN lockout and unlock by rewrite
    present_card(12'h123);
    enter_pin(12'h001);
    enter_pin(12'h002);
    enter_pin(12'h003);
    present_card(12'h123);
    cfg_write(0, 12'h123, 12'h456, 65);
    present_card(12'h123);
    enter_pin(12'h456);
    do_op(4, 0, 12'h000);

    // Inactivity timeout in MENU
    present_card(12'h123);
    enter_pin(12'h456);
    cnt = 0; got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cnt++;
      if (resp_valid) begin
        got = 1;
        break;
      end
    end
    check_val("tmo_seen", got, 1);
    check_val("tmo_cycles", cnt, TIMEOUT);
    check_val("tmo_code", resp_code, C_TIMEOUT);
    check_val("tmo_bal", balance_out, 0);
    m_active = 0; m_menu = 0;
    @(negedge clk);
    check_val("tmo_busy", busy, 0);

    // Host writes during a session are dropped
    present_card(12'h123);
    cfg_write(0, 12'h123, 12'h456, 999);
    enter_pin(12'h456);
    do_op(4, 0, 12'h000);

    // Randomized sessions
    cfg_write(2, 12'h333, 12'h777, $urandom_range(0, MAX_BAL));
    cfg_write(3, 12'h333, 12'h888, $urandom_range(0, MAX_BAL));
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, 3);
        cfg_write(a, r_accts[a], r_pins[a], $urandom_range(0, MAX_BAL));
      end
      present_card(r_accts[$urandom_range(0, 4)]);
      for (int k = 0; k < 4; k++) begin
        if (!m_active || m_menu) break;
        if ($urandom_range(0, 3) != 0) enter_pin(m_pin[m_sess]);
        else enter_pin(m_pin[m_sess] ^ 12'h001);
      end
      if (m_menu) begin
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) begin
          if (!m_active) break;
          o = $urandom_range(0, 7);
          a = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255);
          do_op(o, a, r_accts[$urandom_range(0, 4)]);
        end
        if (m_active) do_op(4, 0, 12'h000);
      end
    end

    // Reset in EXEC of a withdraw aborts silently and clears the table
    cfg_write(0, 12'h123, 12'h456, 200);
    present_card(12'h123);
    enter_pin(12'h456);
    @(negedge clk);
    op_valid = 1; op = 3'd1; amount = 8'd10; dst_acct = '0;
    @(negedge clk);
    op_valid = 0; rst = 1;
    @(negedge clk);
    check_val("xrst_rv", resp_valid, 0);
    check_val("xrst_disp", dispense, 0);
    check_val("xrst_busy", busy, 0);
    check_val("xrst_bal", balance_out, 0);
    check_val("xrst_damt", dispense_amt, 0);
    rst = 0;
    model_reset();
    present_card(12'h123);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
